control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 4, width of CS_opcode; SHALL be >= 4, with upper bits beyond [3:0] required zero for legal opcodes.
REQ-002 Parameter IMM_WORDS, default 1, immediate words fetched by MVI; SHALL be legal in range 1..4.
REQ-003 Parameter ALU_OT_W, default 3, width of CS_ALU_OT.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  run enable; 0 freezes the sequencer.
REQ-007 CS_opcode  in  OPCODE_W  opcode field of the instruction word currently on the memory bus.
REQ-008 mem_ready  in  1  memory word valid this cycle.
REQ-009 zero_flag  in  1  ALU zero flag, sampled in EXEC.
REQ-010 CS_ALU_OT  out  ALU_OT_W  ALU operation select.
REQ-011 CS_Ins_load, CS_Op1_load, CS_Op2_load, CS_Imm_load, CS_PC_load, CS_PC_inc, CS_Reg_load  out  1 each  datapath strobes.
REQ-012 halted  out  1  high while in HALT; illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-013 States SHALL be RESET, FETCH, DECODE, IMM, EXEC, WB, HALT; strobes SHALL be Moore outputs of the state plus the latched opcode, except FETCH/IMM strobes, which are additionally gated by mem_ready.
REQ-014 Opcode map SHALL be 0 MOV, 1 MVI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 JMP, 9 JZ, A NOP, F HLT; B-E and any nonzero upper bit SHALL be illegal.
REQ-015 ALU_OT codes SHALL be 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 IDLE; outside EXEC/WB the output SHALL be IDLE.
REQ-016 RESET: all strobes 0; next state FETCH.
REQ-017 FETCH: with mem_ready=1, assert CS_Ins_load and CS_PC_inc, latch CS_opcode, go to DECODE; with mem_ready=0, stay with all strobes 0.
REQ-018 DECODE: assert CS_Op1_load for every opcode except NOP/HLT/illegal/JMP; assert CS_Op2_load only for ADD..XOR; next state IMM for MVI, HALT for HLT, EXEC otherwise; for illegal opcodes pulse illegal and go to EXEC.
REQ-019 IMM: for each cycle with mem_ready=1, assert CS_Imm_load and CS_PC_inc and increment the word counter; after word IMM_WORDS go to EXEC; with mem_ready=0, hold with strobes 0 and counter unchanged.
REQ-020 EXEC: drive CS_ALU_OT (MOV/MVI use PASS); ALU ops, MOV and MVI go to WB; JMP asserts CS_PC_load; JZ asserts CS_PC_load iff zero_flag=1; JMP, JZ, NOP and illegal go to FETCH.
REQ-021 WB: assert CS_Reg_load with CS_ALU_OT held at its EXEC value; next state FETCH.
REQ-022 HALT: all strobes 0, ALU_OT IDLE, halted=1; only rst exits.
REQ-023 Latency with mem_ready always 1: ALU/MOV 4 cycles, MVI 4+IMM_WORDS, JMP/JZ/NOP 3, measured from FETCH entry to the next FETCH entry.
REQ-024 en=0: state, opcode latch and counter hold; all strobes 0; ALU_OT IDLE; illegal 0; operation resumes in the same state when en returns to 1.
REQ-025 At most one of CS_PC_inc and CS_PC_load SHALL be high in any cycle.

Reset
REQ-026 rst=1 at a rising edge SHALL force state RESET, clear the opcode latch and word counter, and drive strobes 0, ALU_OT IDLE, halted 0 and illegal 0 in the following cycle, regardless of en or the current state, including mid-IMM and HALT.
REQ-027 rst SHALL take priority over en.

Structure
REQ-028 Package cpu_ctrl_pkg SHALL hold the state enum, opcode constants and ALU_OT constants, shared with the ALU and datapath.
REQ-029 A combinational sub-module ctrl_decode (opcode -> ALU_OT, is_alu, is_two_op, is_jump, is_illegal) SHALL be instantiated once.

Verification
REQ-030 ADD (opcode 2), mem_ready=1 -> Ins_load at cycle 0, Op1_load+Op2_load at cycle 1, ALU_OT=1 at cycles 2-3, Reg_load at cycle 3, FETCH again at cycle 4.
REQ-031 MVI with IMM_WORDS=2 and mem_ready low for 3 cycles between the two words -> exactly 2 Imm_load pulses, and PC_inc count = 3 for the instruction.
REQ-032 JZ with zero_flag=0, then JZ with zero_flag=1 -> PC_load 0 then 1, each instruction 3 cycles.
REQ-033 Opcode D -> one illegal pulse in DECODE, no Reg_load, return to FETCH.
REQ-034 HLT, then en toggling for 5 cycles -> halted stays 1; rst pulse -> RESET, then FETCH.
REQ-035 rst asserted during IMM word 1 -> next cycle all strobes 0; the following MVI fetches IMM_WORDS fresh words.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control path: sequencer state encoding,
// opcode constants and ALU operation-select codes. Also imported by the ALU
// and datapath so every block agrees on the same encodings.
// Contents:
//   state_t   - sequencer FSM states
//   OP_*      - 4-bit opcode constants
//   ALU_*     - 3-bit ALU operation-select constants
//   alu_ot_of - opcode -> ALU operation select
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_IMM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_MVI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_NOT  = 3'd6;
  localparam logic [2:0] ALU_IDLE = 3'd7;

  // Register moves (MOV/MVI) route the operand straight through the ALU.
  function automatic logic [2:0] alu_ot_of(input logic [3:0] op);
    case (op)
      OP_MOV, OP_MVI: alu_ot_of = ALU_PASS;
      OP_ADD:         alu_ot_of = ALU_ADD;
      OP_SUB:         alu_ot_of = ALU_SUB;
      OP_AND:         alu_ot_of = ALU_AND;
      OP_OR:          alu_ot_of = ALU_OR;
      OP_XOR:         alu_ot_of = ALU_XOR;
      OP_NOT:         alu_ot_of = ALU_NOT;
      default:        alu_ot_of = ALU_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Bundle between the control sequencer and the datapath/memory side.
//   en          - run enable (0 freezes the sequencer)
//   CS_opcode   - opcode field of the word on the memory bus
//   mem_ready   - memory word valid this cycle
//   zero_flag   - ALU zero flag
//   CS_ALU_OT   - ALU operation select
//   CS_*_load / CS_PC_inc - datapath strobes
//   halted      - sequencer sits in HALT
//   illegal     - one-cycle pulse on an undefined opcode
// Modports: master = sequencer, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OT_W = 3
);
  logic                en;
  logic [OPCODE_W-1:0] CS_opcode;
  logic                mem_ready;
  logic                zero_flag;
  logic [ALU_OT_W-1:0] CS_ALU_OT;
  logic                CS_Ins_load;
  logic                CS_Op1_load;
  logic                CS_Op2_load;
  logic                CS_Imm_load;
  logic                CS_PC_load;
  logic                CS_PC_inc;
  logic                CS_Reg_load;
  logic                halted;
  logic                illegal;

  modport master (
    input  en, CS_opcode, mem_ready, zero_flag,
    output CS_ALU_OT, CS_Ins_load, CS_Op1_load, CS_Op2_load, CS_Imm_load,
           CS_PC_load, CS_PC_inc, CS_Reg_load, halted, illegal
  );

  modport slave (
    output en, CS_opcode, mem_ready, zero_flag,
    input  CS_ALU_OT, CS_Ins_load, CS_Op1_load, CS_Op2_load, CS_Imm_load,
           CS_PC_load, CS_PC_inc, CS_Reg_load, halted, illegal
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode classifier used by the sequencer.
// Ports:
//   i_opcode     in  OPCODE_W  latched opcode
//   o_alu_ot     out 3         ALU operation select for this opcode
//   o_is_alu     out 1         ADD..NOT
//   o_is_two_op  out 1         ADD..XOR (needs a second operand)
//   o_is_jump    out 1         JMP or JZ
//   o_is_illegal out 1         B..E, or any nonzero bit above [3:0]
// -----------------------------------------------------------------------------
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic [2:0]          o_alu_ot,
  output logic                o_is_alu,
  output logic                o_is_two_op,
  output logic                o_is_jump,
  output logic                o_is_illegal
);

  logic [3:0] w_op;
  logic       w_upper_nz;

  assign w_op       = i_opcode[3:0];
  // Shift rather than slice so OPCODE_W == 4 needs no special case.
  assign w_upper_nz = ((i_opcode >> 4) != '0);

  always_comb begin
    o_is_illegal = w_upper_nz || (w_op >= 4'hB && w_op <= 4'hE);
    o_is_alu     = !o_is_illegal && (w_op >= OP_ADD && w_op <= OP_NOT);
    o_is_two_op  = !o_is_illegal && (w_op >= OP_ADD && w_op <= OP_XOR);
    o_is_jump    = !o_is_illegal && (w_op == OP_JMP || w_op == OP_JZ);
    o_alu_ot     = o_is_illegal ? ALU_IDLE : alu_ot_of(w_op);
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle instruction sequencer: RESET -> FETCH -> DECODE -> [IMM] ->
// EXEC -> [WB] -> FETCH, with HALT as a sink left only through rst.
// Ports:
//   clk  in  sole clock, rising edge
//   rst  in  synchronous active-high reset (priority over en)
//   bus  master modport of control_sequencer_if (enable, opcode, handshake,
//        flags in; ALU select, datapath strobes, halted, illegal out)
// Strobes are Moore outputs of state + latched opcode; FETCH/IMM strobes are
// additionally qualified by mem_ready. en=0 freezes all state and forces
// every strobe low.
// -----------------------------------------------------------------------------
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int IMM_WORDS = 1,
  parameter int ALU_OT_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  localparam int CNT_W = 3;

  state_t              r_state;
  state_t              w_state_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [OPCODE_W-1:0] w_opcode_next;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_cnt_inc;

  logic [2:0] w_dec_alu;
  logic       w_dec_is_alu;
  logic       w_dec_two_op;
  logic       w_dec_jump;
  logic       w_dec_illegal;
  logic [3:0] w_op;

  logic [2:0] w_alu_ot;
  logic       w_ins_load, w_op1_load, w_op2_load, w_imm_load;
  logic       w_pc_load, w_pc_inc, w_reg_load, w_illegal;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .i_opcode     (r_opcode),
    .o_alu_ot     (w_dec_alu),
    .o_is_alu     (w_dec_is_alu),
    .o_is_two_op  (w_dec_two_op),
    .o_is_jump    (w_dec_jump),
    .o_is_illegal (w_dec_illegal)
  );

  assign w_op      = r_opcode[3:0];
  assign w_cnt_inc = r_word_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_opcode   <= '0;
      r_word_cnt <= '0;
    end else if (bus.en) begin
      r_state    <= w_state_next;
      r_opcode   <= w_opcode_next;
      r_word_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_opcode_next = r_opcode;
    w_cnt_next    = r_word_cnt;
    w_alu_ot      = ALU_IDLE;
    w_ins_load    = 1'b0;
    w_op1_load    = 1'b0;
    w_op2_load    = 1'b0;
    w_imm_load    = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    w_reg_load    = 1'b0;
    w_illegal     = 1'b0;

    if (bus.en) begin
      unique case (r_state)
        ST_RESET: w_state_next = ST_FETCH;

        ST_FETCH: begin
          if (bus.mem_ready) begin
            w_ins_load    = 1'b1;
            w_pc_inc      = 1'b1;
            w_opcode_next = bus.CS_opcode;
            w_state_next  = ST_DECODE;
          end
        end

        ST_DECODE: begin
          w_op1_load = !(w_dec_illegal || w_op == OP_NOP ||
                         w_op == OP_HLT || w_op == OP_JMP);
          w_op2_load = w_dec_two_op;
          w_illegal  = w_dec_illegal;
          if (w_dec_illegal)       w_state_next = ST_EXEC;
          else if (w_op == OP_MVI) w_state_next = ST_IMM;
          else if (w_op == OP_HLT) w_state_next = ST_HALT;
          else                     w_state_next = ST_EXEC;
        end

        ST_IMM: begin
          if (bus.mem_ready) begin
            w_imm_load = 1'b1;
            w_pc_inc   = 1'b1;
            // Counter returns to zero on the last word so the next MVI
            // starts fresh without a separate clear.
            if (w_cnt_inc == CNT_W'(IMM_WORDS)) begin
              w_cnt_next   = '0;
              w_state_next = ST_EXEC;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end

        ST_EXEC: begin
          w_alu_ot = w_dec_alu;
          if (w_dec_illegal) begin
            w_state_next = ST_FETCH;
          end else if (w_dec_is_alu || w_op == OP_MOV || w_op == OP_MVI) begin
            w_state_next = ST_WB;
          end else begin
            if (w_dec_jump) w_pc_load = (w_op == OP_JMP) || bus.zero_flag;
            w_state_next = ST_FETCH;
          end
        end

        ST_WB: begin
          w_alu_ot     = w_dec_alu;
          w_reg_load   = 1'b1;
          w_state_next = ST_FETCH;
        end

        ST_HALT: w_state_next = ST_HALT;

        default: w_state_next = ST_RESET;
      endcase
    end
  end

  assign bus.CS_ALU_OT   = ALU_OT_W'(w_alu_ot);
  assign bus.CS_Ins_load = w_ins_load;
  assign bus.CS_Op1_load = w_op1_load;
  assign bus.CS_Op2_load = w_op2_load;
  assign bus.CS_Imm_load = w_imm_load;
  assign bus.CS_PC_load  = w_pc_load;
  assign bus.CS_PC_inc   = w_pc_inc;
  assign bus.CS_Reg_load = w_reg_load;
  assign bus.illegal     = w_illegal;
  // halted reflects the state itself, so it stays high even while en=0.
  assign bus.halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Instruction table (per-instruction strobe totals and latency, tracked with
// a scoreboard queue) plus per-cycle sequences for ADD timing, en freeze,
// HLT, MVI with mem_ready gaps, and reset in the middle of IMM.
// Strobe vector bit order: {Ins, Op1, Op2, Imm, PC_load, PC_inc, Reg, illegal}
// -----------------------------------------------------------------------------
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int OPW  = 5;
  localparam int IMMW = 2;
  localparam int ALUW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.OPCODE_W(OPW), .ALU_OT_W(ALUW)) bus();

  control_sequencer #(.OPCODE_W(OPW), .IMM_WORDS(IMMW), .ALU_OT_W(ALUW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] s_vec;
  assign s_vec = {bus.CS_Ins_load, bus.CS_Op1_load, bus.CS_Op2_load, bus.CS_Imm_load,
                  bus.CS_PC_load, bus.CS_PC_inc, bus.CS_Reg_load, bus.illegal};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [OPW-1:0] op;
    logic           zf;
    int cycles, op1, op2, imm, pcinc, pcload, regl, ill, alucyc;
    logic [2:0]     alu;
  } ins_t;

  typedef struct {
    logic           rst, en, rdy;
    logic [OPW-1:0] op;
    logic [7:0]     s;
    logic [2:0]     alu;
    logic           halt;
  } cyc_t;

  ins_t tbl[$];
  ins_t sb[$];
  cyc_t seq[$];

  function automatic ins_t mk(input logic [OPW-1:0] op, input logic zf,
                              input int cycles, op1, op2, imm, pcinc, pcload, regl, ill,
                              input logic [2:0] alu, input int alucyc);
    ins_t r;
    r.op = op; r.zf = zf; r.cycles = cycles; r.op1 = op1; r.op2 = op2; r.imm = imm;
    r.pcinc = pcinc; r.pcload = pcload; r.regl = regl; r.ill = ill;
    r.alu = alu; r.alucyc = alucyc;
    return r;
  endfunction

  function automatic cyc_t mkc(input logic r, input logic e, input logic rdy,
                               input logic [OPW-1:0] op, input logic [7:0] s,
                               input logic [2:0] alu, input logic halt);
    cyc_t c;
    c.rst = r; c.en = e; c.rdy = rdy; c.op = op; c.s = s; c.alu = alu; c.halt = halt;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in RESET, positioned just after a rising edge.
  task automatic do_reset();
    tick();
    rst    = 1'b1;
    bus.en = 1'b1;
    tick();
    rst    = 1'b0;
  endtask

  task automatic run_seq(input string nm);
    cyc_t r, e;
    cyc_t expq[$];
    do_reset();
    for (int i = 0; i < seq.size(); i++) begin
      r = seq[i];
      rst = r.rst; bus.en = r.en; bus.mem_ready = r.rdy;
      bus.CS_opcode = r.op; bus.zero_flag = 1'b0;
      expq.push_back(r);
      #1;
      e = expq.pop_front();
      total++;
      if (s_vec !== e.s || bus.CS_ALU_OT !== e.alu || bus.halted !== e.halt) begin
        bad++;
        $display("FAIL %s row %0d: got strobes=%b alu=%0d halted=%b, want strobes=%b alu=%0d halted=%b",
                 nm, i, s_vec, bus.CS_ALU_OT, bus.halted, e.s, e.alu, e.halt);
      end else begin
        $display("%s row %0d: strobes=%b alu=%0d halted=%b ok", nm, i, s_vec, bus.CS_ALU_OT, bus.halted);
      end
      tick();
    end
    rst = 1'b0;
    seq.delete();
  endtask

  initial begin : main
    int fetched, next_drive, cyc, ovl, alucyc;
    int a_op1, a_op2, a_imm, a_inc, a_ld, a_reg, a_ill;
    logic [2:0] alu_last;
    logic done, got_fetch;
    ins_t e;

    bus.en = 1'b0; bus.CS_opcode = '0; bus.mem_ready = 1'b0; bus.zero_flag = 1'b0;

    // ---------------- instruction table (IMM_WORDS = 2) ----------------
    //               op     zf cyc op1 op2 imm inc ld reg ill alu       alucyc
    tbl.push_back(mk(5'h00, 0, 4, 1, 0, 0, 1, 0, 1, 0, ALU_PASS, 2));
    tbl.push_back(mk(5'h01, 0, 6, 1, 0, 2, 3, 0, 1, 0, ALU_PASS, 2));
    tbl.push_back(mk(5'h02, 0, 4, 1, 1, 0, 1, 0, 1, 0, ALU_ADD,  2));
    tbl.push_back(mk(5'h03, 0, 4, 1, 1, 0, 1, 0, 1, 0, ALU_SUB,  2));
    tbl.push_back(mk(5'h04, 0, 4, 1, 1, 0, 1, 0, 1, 0, ALU_AND,  2));
    tbl.push_back(mk(5'h05, 0, 4, 1, 1, 0, 1, 0, 1, 0, ALU_OR,   2));
    tbl.push_back(mk(5'h06, 0, 4, 1, 1, 0, 1, 0, 1, 0, ALU_XOR,  2));
    tbl.push_back(mk(5'h07, 0, 4, 1, 0, 0, 1, 0, 1, 0, ALU_NOT,  2));
    tbl.push_back(mk(5'h08, 0, 3, 0, 0, 0, 1, 1, 0, 0, ALU_IDLE, 0));
    tbl.push_back(mk(5'h09, 0, 3, 1, 0, 0, 1, 0, 0, 0, ALU_IDLE, 0));
    tbl.push_back(mk(5'h09, 1, 3, 1, 0, 0, 1, 1, 0, 0, ALU_IDLE, 0));
    tbl.push_back(mk(5'h0A, 1, 3, 0, 0, 0, 1, 0, 0, 0, ALU_IDLE, 0));
    tbl.push_back(mk(5'h0D, 0, 3, 0, 0, 0, 1, 0, 0, 1, ALU_IDLE, 0));
    tbl.push_back(mk(5'h0B, 0, 3, 0, 0, 0, 1, 0, 0, 1, ALU_IDLE, 0));
    tbl.push_back(mk(5'h12, 0, 3, 0, 0, 0, 1, 0, 0, 1, ALU_IDLE, 0));
    tbl.push_back(mk(5'h0E, 0, 3, 0, 0, 0, 1, 0, 0, 1, ALU_IDLE, 0));

    do_reset();
    bus.en = 1'b1; bus.mem_ready = 1'b1;
    bus.CS_opcode = tbl[0].op;
    sb.push_back(tbl[0]);
    next_drive = 1;
    fetched = -1; done = 1'b0;
    cyc = 0; ovl = 0; alucyc = 0; alu_last = ALU_IDLE;
    a_op1 = 0; a_op2 = 0; a_imm = 0; a_inc = 0; a_ld = 0; a_reg = 0; a_ill = 0;

    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      got_fetch = bus.CS_Ins_load;
      if (got_fetch) begin
        if (fetched >= 0) begin
          e = sb.pop_front();
          total++;
          if (cyc != e.cycles || a_op1 != e.op1 || a_op2 != e.op2 || a_imm != e.imm ||
              a_inc != e.pcinc || a_ld != e.pcload || a_reg != e.regl || a_ill != e.ill ||
              alu_last !== e.alu || alucyc != e.alucyc || ovl != 0) begin
            bad++;
            $display("FAIL instr %0d op=%h zf=%b: got cyc=%0d op1=%0d op2=%0d imm=%0d inc=%0d ld=%0d reg=%0d ill=%0d alu=%0d alucyc=%0d overlap=%0d, want cyc=%0d op1=%0d op2=%0d imm=%0d inc=%0d ld=%0d reg=%0d ill=%0d alu=%0d alucyc=%0d overlap=0",
                     fetched, e.op, e.zf, cyc, a_op1, a_op2, a_imm, a_inc, a_ld, a_reg, a_ill, alu_last, alucyc, ovl,
                     e.cycles, e.op1, e.op2, e.imm, e.pcinc, e.pcload, e.regl, e.ill, e.alu, e.alucyc);
          end else begin
            $display("instr %0d op=%h zf=%b: %0d cycles, strobe totals ok", fetched, e.op, e.zf, cyc);
          end
        end
        fetched++;
        if (fetched == tbl.size()) done = 1'b1;
        cyc = 0; ovl = 0; alucyc = 0; alu_last = ALU_IDLE;
        a_op1 = 0; a_op2 = 0; a_imm = 0; a_inc = 0; a_ld = 0; a_reg = 0; a_ill = 0;
      end
      cyc++;
      a_op1 += int'(bus.CS_Op1_load); a_op2 += int'(bus.CS_Op2_load);
      a_imm += int'(bus.CS_Imm_load); a_inc += int'(bus.CS_PC_inc);
      a_ld  += int'(bus.CS_PC_load);  a_reg += int'(bus.CS_Reg_load);
      a_ill += int'(bus.illegal);
      if (bus.CS_PC_inc && bus.CS_PC_load) ovl++;
      if (bus.CS_ALU_OT != ALU_IDLE) begin
        alucyc++;
        alu_last = bus.CS_ALU_OT;
      end
      tick();
      if (got_fetch && !done) begin
        // zero_flag belongs to the instruction just fetched; the opcode bus
        // already presents the next one.
        bus.zero_flag = tbl[fetched].zf;
        if (next_drive < tbl.size()) begin
          bus.CS_opcode = tbl[next_drive].op;
          sb.push_back(tbl[next_drive]);
        end else begin
          bus.CS_opcode = {1'b0, OP_NOP};
        end
        next_drive++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL instr_table_timeout: got %0d fetches, want %0d", fetched, tbl.size());
    end

    // ---------------- ADD cycle-exact ----------------
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b0110_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b0000_0000, ALU_ADD,  0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b0000_0010, ALU_ADD,  0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b1000_0100, ALU_IDLE, 0));
    run_seq("add_timing");

    // ---------------- en freeze during ADD ----------------
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 0, 1, 5'h02, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h02, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 0, 1, 5'h03, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 0, 1, 5'h03, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h03, 8'b0110_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 0, 1, 5'h03, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h03, 8'b0000_0000, ALU_ADD,  0));
    seq.push_back(mkc(0, 1, 1, 5'h03, 8'b0000_0010, ALU_ADD,  0));
    seq.push_back(mkc(0, 1, 1, 5'h03, 8'b1000_0100, ALU_IDLE, 0));
    run_seq("en_freeze");

    // ---------------- HLT, en toggling, rst exit ----------------
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(0, 0, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(0, 0, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(1, 0, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 1));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h0F, 8'b1000_0100, ALU_IDLE, 0));
    run_seq("halt");

    // ---------------- MVI with mem_ready gaps ----------------
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 0, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0100_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0001_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 0, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 0, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 0, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0001_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0000, ALU_PASS, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0010, ALU_PASS, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b1000_0100, ALU_IDLE, 0));
    run_seq("mvi_gaps");

    // ---------------- rst during IMM word 1 ----------------
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0100_0000, ALU_IDLE, 0));
    seq.push_back(mkc(1, 1, 1, 5'h01, 8'b0001_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b1000_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0100_0000, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0001_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0001_0100, ALU_IDLE, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0000, ALU_PASS, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b0000_0010, ALU_PASS, 0));
    seq.push_back(mkc(0, 1, 1, 5'h01, 8'b1000_0100, ALU_IDLE, 0));
    run_seq("rst_in_imm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
